// File: rtl/conversor_bcd_if.sv
// Bus between the CPU output register and the binary-to-BCD converter feeding
// the seven-segment decoders.
interface conversor_bcd_if #(
  parameter int unsigned LARGURA = 16,
  parameter int unsigned DIGITOS = 5
);
  logic                   iniciar;
  logic [LARGURA-1:0]     valor;
  logic                   ocupado;
  logic                   pronto;
  logic [4*DIGITOS-1:0]   digitos;
  logic [DIGITOS-1:0]     habilita;
  logic [3:0]             sinal;
  logic                   sinal_ativo;

  modport master (
    output iniciar, valor,
    input  ocupado, pronto, digitos, habilita, sinal, sinal_ativo
  );

  modport slave (
    input  iniciar, valor,
    output ocupado, pronto, digitos, habilita, sinal, sinal_ativo
  );
endinterface

// File: rtl/conversor_bcd.sv
// Iterative double-dabble binary-to-BCD converter with registered, blanked digit outputs.
// Define CONVERSOR_BCD_SINAL_EN to treat valor as two's complement and drive the minus digit.
module conversor_bcd #(
  parameter int unsigned LARGURA = 16,
  parameter int unsigned DIGITOS = 5
) (
  input logic             clock,
  input logic             reset,
  conversor_bcd_if.slave  bus
);

  localparam int unsigned CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam int unsigned BW = 4 * DIGITOS;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FINALIZA = 2'd2
  } estado_t;

  estado_t            estado, proximo;
  logic [LARGURA-1:0] desloc;
  logic [LARGURA-1:0] magnitude;
  logic [BW-1:0]      bcd;
  logic [BW-1:0]      bcd_ajustado;
  logic [BW-1:0]      digitos_r;
  logic [CW-1:0]      passo;
  logic [DIGITOS-1:0] habilita_r;
  logic [DIGITOS-1:0] habilita_calc;
  logic               algum;
  logic               pronto_r;
  logic               ultimo_passo;

  assign ultimo_passo = (passo == CW'(LARGURA - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= proximo;
  end

  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:   if (bus.iniciar) proximo = CONVERTE;
      CONVERTE: if (ultimo_passo) proximo = FINALIZA;
      FINALIZA: proximo = OCIOSO;
      default:  proximo = OCIOSO;
    endcase
  end

  always_comb begin
    bcd_ajustado = bcd;
    for (int unsigned i = 0; i < DIGITOS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_ajustado[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Scan from the most significant digit down so each enable sees every digit above it.
  always_comb begin
    habilita_calc = '0;
    algum         = 1'b0;
    for (int unsigned k = 0; k < DIGITOS; k++) begin
      algum = algum | (|bcd[4*(DIGITOS-1-k) +: 4]);
      habilita_calc[DIGITOS-1-k] = algum;
    end
    habilita_calc[0] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      desloc     <= '0;
      bcd        <= '0;
      passo      <= '0;
      digitos_r  <= '0;
      habilita_r <= '0;
      pronto_r   <= 1'b0;
    end else begin
      pronto_r <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.iniciar) begin
            desloc <= magnitude;
            bcd    <= '0;
            passo  <= '0;
          end
        end
        CONVERTE: begin
          bcd    <= {bcd_ajustado[BW-2:0], desloc[LARGURA-1]};
          desloc <= desloc << 1;
          passo  <= passo + 1'b1;
        end
        FINALIZA: begin
          digitos_r  <= bcd;
          habilita_r <= habilita_calc;
          pronto_r   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CONVERSOR_BCD_SINAL_EN
  logic       negativo;
  logic       negativo_r;
  logic [3:0] sinal_r;
  logic       sinal_ativo_r;

  assign negativo  = bus.valor[LARGURA-1];
  assign magnitude = negativo ? (~bus.valor + 1'b1) : bus.valor;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      negativo_r    <= 1'b0;
      sinal_r       <= 4'd15;
      sinal_ativo_r <= 1'b0;
    end else begin
      if (estado == OCIOSO && bus.iniciar) negativo_r <= negativo;
      if (estado == FINALIZA) begin
        sinal_r       <= negativo_r ? 4'd10 : 4'd15;
        sinal_ativo_r <= negativo_r;
      end
    end
  end

  assign bus.sinal       = sinal_r;
  assign bus.sinal_ativo = sinal_ativo_r;
`else
  assign magnitude       = bus.valor;
  assign bus.sinal       = 4'd15;
  assign bus.sinal_ativo = 1'b0;
`endif

  assign bus.ocupado  = (estado != OCIOSO);
  assign bus.pronto   = pronto_r;
  assign bus.digitos  = digitos_r;
  assign bus.habilita = habilita_r;

endmodule

// File: tb/tb_conversor_bcd.sv
// Scoreboard bench for conversor_bcd: a decimal reference model predicts each accepted
// conversion and its completion cycle; a negedge monitor checks every pronto pulse.
module tb_conversor_bcd;

  localparam int unsigned L = 16;
  localparam int unsigned D = 5;

  typedef struct packed {
    logic [4*D-1:0] dig;
    logic [D-1:0]   hab;
    logic [3:0]     sin;
    logic           ativo;
    int unsigned    quando;
  } exp_t;

  logic clock;
  logic reset;

  conversor_bcd_if #(.LARGURA(L), .DIGITOS(D)) bus ();

  conversor_bcd #(.LARGURA(L), .DIGITOS(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned total;
  int unsigned bad;
  int unsigned ciclo;
  int unsigned livre_em;
  exp_t        fila[$];
  exp_t        visto;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    total++;
    if (atual !== esperado) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nome, atual, esperado, ciclo);
    end
  endtask

  function automatic exp_t modelo(input logic [L-1:0] v);
    exp_t        r;
    int unsigned m;
    int unsigned p;
    r       = '0;
    m       = v;
    r.sin   = 4'd15;
    r.ativo = 1'b0;
`ifdef CONVERSOR_BCD_SINAL_EN
    if (v[L-1]) begin
      m       = (32'd1 << L) - m;
      r.sin   = 4'd10;
      r.ativo = 1'b1;
    end
`endif
    p = 1;
    for (int i = 0; i < D; i++) begin
      r.dig[4*i +: 4] = 4'((m / p) % 10);
      r.hab[i]        = (i == 0) || (m >= p);
      p               = p * 10;
    end
    return r;
  endfunction

  // Called at a negedge; drives iniciar so it is sampled at posedge number e.
  task automatic iniciar_em(input int unsigned e, input logic [L-1:0] v);
    exp_t x;
    logic aceito;
    while (ciclo + 1 < e) @(negedge clock);
    bus.iniciar = 1'b1;
    bus.valor   = v;
    aceito      = (ciclo + 1 >= livre_em);
    if (aceito) begin
      x        = modelo(v);
      x.quando = ciclo + 1 + 17;
      fila.push_back(x);
      livre_em = ciclo + 1 + 18;
    end
    @(negedge clock);
    bus.iniciar = 1'b0;
    if (aceito) verifica("ocupado_apos_inicio", 32'(bus.ocupado), 32'd1);
  endtask

  task automatic espera_vazio(input int unsigned limite);
    int unsigned n;
    n = 0;
    while (fila.size() != 0 && n < limite) begin
      @(negedge clock);
      n++;
    end
    if (fila.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending results expected 0", fila.size());
      fila.delete();
    end
    @(negedge clock);
  endtask

  task automatic verifica_reset(input string tag);
    verifica({tag, "_ocupado"},  32'(bus.ocupado),     32'd0);
    verifica({tag, "_pronto"},   32'(bus.pronto),      32'd0);
    verifica({tag, "_digitos"},  32'(bus.digitos),     32'd0);
    verifica({tag, "_habilita"}, 32'(bus.habilita),    32'd0);
    verifica({tag, "_sinal"},    32'(bus.sinal),       32'd15);
    verifica({tag, "_ativo"},    32'(bus.sinal_ativo), 32'd0);
  endtask

  always @(negedge clock) begin
    if (reset && bus.pronto) begin
      if (fila.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pronto_espurio: got pronto=1 expected no pending result (cycle %0d)", ciclo);
      end else begin
        visto = fila.pop_front();
        verifica("digitos",      32'(bus.digitos),     32'(visto.dig));
        verifica("habilita",     32'(bus.habilita),    32'(visto.hab));
        verifica("sinal",        32'(bus.sinal),       32'(visto.sin));
        verifica("sinal_ativo",  32'(bus.sinal_ativo), 32'(visto.ativo));
        verifica("latencia",     ciclo,                visto.quando);
        verifica("ocupado_pronto", 32'(bus.ocupado),   32'd0);
      end
    end
  end

  logic [L-1:0] dirigidos [5];
  int unsigned  e0;
  logic [L-1:0] rv;

  initial begin
    total       = 0;
    bad         = 0;
    ciclo       = 0;
    livre_em    = 0;
    reset       = 1'b0;
    bus.iniciar = 1'b0;
    bus.valor   = '0;
    dirigidos   = '{16'd12345, 16'd0, 16'd907, 16'h8000, 16'hFFF9};

    repeat (3) @(negedge clock);
    verifica_reset("rst_inicial");
    reset = 1'b1;
    @(negedge clock);

    foreach (dirigidos[i]) begin
      iniciar_em(ciclo + 1, dirigidos[i]);
      espera_vazio(40);
    end

    // Abort a conversion of 12345 with an asynchronous reset five cycles in.
    iniciar_em(ciclo + 1, 16'd12345);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    verifica_reset("rst_meio");
    fila.delete();
    @(negedge clock);
    reset    = 1'b1;
    livre_em = 0;
    repeat (25) @(negedge clock);
    verifica("rst_sem_pronto_digitos", 32'(bus.digitos), 32'd0);

    // Start during busy is dropped; start in the pronto cycle is taken.
    e0 = ciclo + 1;
    iniciar_em(e0, 16'd42);
    iniciar_em(e0 + 5, 16'd999);
    iniciar_em(e0 + 18, 16'd999);
    espera_vazio(60);

    for (int n = 0; n < 50; n++) begin
      rv = L'($urandom);
      case ($urandom_range(0, 7))
        0: rv = '0;
        1: rv = '1;
        2: rv = 16'h8000;
        3: rv = 16'h7FFF;
        default: ;
      endcase
      iniciar_em(ciclo + 1 + $urandom_range(0, 22), rv);
    end
    espera_vazio(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
